spi_master: RTL and testbench

- Single-byte, full-duplex SPI master engine.
- Accepts one byte with a valid strobe, shifts it out MSB-first on MOSI while shifting in MISO, then returns the received byte with a one-cycle valid pulse.
- Used by flash-loader logic that issues command/address bytes and dummy bytes to stream SPI flash contents.
- Chip select is not generated here; the client drives CS.

---
 rtl/spi_master_if.sv | 27 ++
 rtl/spi_master.sv | 162 ++++++++++++++++
 tb/tb_spi_master.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Byte-level client bus and SPI pins for the single-byte SPI master.
//
// Handshake: a byte is accepted on a rising clk edge where tx_dv and
// tx_ready are both high; tx_byte is captured on that same edge and tx_dv
// while tx_ready is low is ignored. rx_dv is a one-cycle pulse with no
// backpressure, and rx_byte is valid in that cycle and holds until the
// next completed byte.
interface spi_master_if;
  logic [7:0] tx_byte;
  logic       tx_dv;
  logic       tx_ready;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       spi_clk;
  logic       spi_miso;
  logic       spi_mosi;

  modport master (
    input  tx_byte, tx_dv, spi_miso,
    output tx_ready, rx_dv, rx_byte, spi_clk, spi_mosi
  );

  modport slave (
    output tx_byte, tx_dv, spi_miso,
    input  tx_ready, rx_dv, rx_byte, spi_clk, spi_mosi
  );
endinterface

// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master: shifts a byte out MSB-first on MOSI
// while shifting MISO in, then pulses rx_dv with the received byte.
// Chip select is left to the client. All outputs come from registers.
module spi_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus,
  output logic [1:0]    dbg_state
);

  localparam logic CPOL = (SPI_MODE & 2) != 0;
  localparam logic CPHA = (SPI_MODE & 1) != 0;
  localparam int   CW   = $clog2(2 * CLKS_PER_HALF_BIT);
  localparam logic [CW-1:0] LEAD_AT  = CW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] TRAIL_AT = CW'(2 * CLKS_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [4:0]      edge_cnt;
  logic [CW-1:0]   half_cnt;
  logic            int_clk;
  logic            spi_clk_q;
  logic            lead_q, trail_q;      // internal edge, one cycle late
  logic            lead_q2, trail_q2;    // aligned with the visible spi_clk edge
  logic [7:0]      tx_reg;
  logic [2:0]      tx_bit;
  logic            mosi_q;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift, rx_next;
  logic            rx_dv_q;
  logic [7:0]      rx_byte_q;
  logic            accept, lead_now, trail_now, shift_ev, sample_ev;

  assign accept    = bus.tx_dv && (state == ST_IDLE);
  assign lead_now  = (state == ST_XFER) && (edge_cnt != 5'd0) && (half_cnt == LEAD_AT);
  assign trail_now = (state == ST_XFER) && (edge_cnt != 5'd0) && (half_cnt == TRAIL_AT);
  // The edge that would follow the 16th one is suppressed via edge_cnt so
  // MOSI keeps the last bit once the byte is done.
  assign shift_ev  = (CPHA ? lead_q : trail_q) && (edge_cnt != 5'd0);
  assign sample_ev = CPHA ? trail_q2 : lead_q2;

  assign bus.tx_ready = (state == ST_IDLE);
  assign bus.rx_dv    = rx_dv_q;
  assign bus.rx_byte  = rx_byte_q;
  assign bus.spi_clk  = spi_clk_q;
  assign bus.spi_mosi = mosi_q;
  assign dbg_state    = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= next_state;
  end

  // Next state: one reset cycle, then idle, transfer until all edges are out.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_RESET: next_state = ST_IDLE;
      ST_IDLE:  if (bus.tx_dv) next_state = ST_XFER;
      ST_XFER:  if (edge_cnt == 5'd0) next_state = ST_IDLE;
      default:  next_state = ST_RESET;
    endcase
  end

  // SPI clock generation: half-period counter, edge counter, edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt  <= 5'd0;
      half_cnt  <= '0;
      int_clk   <= CPOL;
      spi_clk_q <= CPOL;
      lead_q    <= 1'b0;
      trail_q   <= 1'b0;
      lead_q2   <= 1'b0;
      trail_q2  <= 1'b0;
    end else begin
      spi_clk_q <= int_clk;
      lead_q    <= lead_now;
      trail_q   <= trail_now;
      lead_q2   <= lead_q;
      trail_q2  <= trail_q;
      if (accept) begin
        edge_cnt <= 5'd16;
        // The accept cycle itself counts as half-period count 0.
        half_cnt <= CW'(1);
      end else if (state == ST_XFER && edge_cnt != 5'd0) begin
        if (trail_now) begin
          half_cnt <= '0;
          edge_cnt <= edge_cnt - 5'd1;
          int_clk  <= ~int_clk;
        end else if (lead_now) begin
          half_cnt <= half_cnt + CW'(1);
          edge_cnt <= edge_cnt - 5'd1;
          int_clk  <= ~int_clk;
        end else begin
          half_cnt <= half_cnt + CW'(1);
        end
      end
    end
  end

  // Transmit path: latch the byte, present bit 7 early for CPHA=0, then
  // step MSB-first on each shifting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_reg <= 8'h00;
      tx_bit <= 3'd7;
      mosi_q <= 1'b0;
    end else if (accept) begin
      tx_reg <= bus.tx_byte;
      if (CPHA) begin
        tx_bit <= 3'd7;
      end else begin
        mosi_q <= bus.tx_byte[7];
        tx_bit <= 3'd6;
      end
    end else if (shift_ev) begin
      mosi_q <= tx_reg[tx_bit];
      tx_bit <= tx_bit - 3'd1;
    end
  end

  // Insert the sampled MISO bit into the shift image.
  always_comb begin
    rx_next         = rx_shift;
    rx_next[rx_bit] = bus.spi_miso;
  end

  // Receive path: capture MISO at each sampling edge; bit 0 completes the byte.
  // The final CPHA=1 sample can coincide with the next accept, so the
  // sample wins over the counter reload (it wraps to 7 by itself).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_bit    <= 3'd7;
      rx_shift  <= 8'h00;
      rx_dv_q   <= 1'b0;
      rx_byte_q <= 8'h00;
    end else begin
      rx_dv_q <= 1'b0;
      if (sample_ev) begin
        rx_shift <= rx_next;
        rx_bit   <= rx_bit - 3'd1;
        if (rx_bit == 3'd0) begin
          rx_dv_q   <= 1'b1;
          rx_byte_q <= rx_next;
        end
      end else if (accept) begin
        rx_bit <= 3'd7;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: all four SPI modes run side by side on the same
// client stimulus; each has its own slave byte or a MOSI->MISO loopback.
module tb_spi_master;

  localparam int H    = 3;
  localparam int FULL = 16 * H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_drv    = 1'b1;
  logic       tx_dv_drv  = 1'b0;
  logic [7:0] tx_byte_drv = 8'h00;
  logic [3:0] miso_drv   = 4'h0;

  logic [3:0] obs_clk, obs_mosi, obs_ready, obs_dv;
  logic [7:0] obs_rx [4];
  logic [1:0] dbg_state [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    spi_master_if bus ();
    assign bus.tx_byte  = tx_byte_drv;
    assign bus.tx_dv    = tx_dv_drv;
    assign bus.spi_miso = miso_drv[gi];
    assign obs_clk[gi]   = bus.spi_clk;
    assign obs_mosi[gi]  = bus.spi_mosi;
    assign obs_ready[gi] = bus.tx_ready;
    assign obs_dv[gi]    = bus.rx_dv;
    assign obs_rx[gi]    = bus.rx_byte;

    spi_master #(.SPI_MODE(gi), .CLKS_PER_HALF_BIT(H)) u_dut (
      .clk       (clk),
      .rst       (rst_drv),
      .bus       (bus.master),
      .dbg_state (dbg_state[gi])
    );
  end

  // ---------------- reference model state ----------------
  typedef struct {
    int         g;
    int         due;
    logic [7:0] val;
  } rx_exp_t;
  rx_exp_t exp_q[$];

  int         cyc = 0;
  bit         rst_q = 1'b1;
  bit         has_t0 = 1'b0;
  int         t0 = 0;
  logic [7:0] cur_tx = 8'h00;
  logic [7:0] cur_slv [4];
  bit         cur_lb = 1'b0;
  logic [3:0] prev_mosi = 4'h0;
  logic [3:0] exp_mosi_now = 4'h0;
  bit         exp_ready_now = 1'b0;
  logic [7:0] exp_rx [4];
  int         vec_cnt = 0;
  int         err_cnt = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input int g, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s mode%0d cyc=%0d got=%h exp=%h", tag, g, cyc, got, exp);
    end
  endtask

  // Visible SPI clock edges so far, j cycles after the accept cycle.
  function automatic int edges_seen(input int j);
    int e;
    if (j < 1) return 0;
    e = (j - 1) / H;
    return (e > 16) ? 16 : e;
  endfunction

  // Bit shown on a data line after n visible edges, MSB first. CPHA=0 shows
  // bit 7 up front and moves on each trailing edge; CPHA=1 moves on each
  // leading edge and holds the previous level before the first one.
  function automatic logic bit_at(input logic [7:0] b, input int g, input int n, input logic prev);
    int k;
    if (g % 2 == 0) begin
      k = n / 2;
      if (k > 7) k = 7;
      return b[7 - k];
    end
    k = (n + 1) / 2;
    if (k == 0) return prev;
    return b[8 - k];
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: check outputs mid-cycle, then drive MISO for this cycle.
  task automatic step();
    int  j;
    int  n;
    logic dv_exp, clk_exp, mosi_exp;
    @(posedge clk);
    rst_q = rst_drv;
    @(negedge clk);
    cyc++;
    if (rst_q) begin
      has_t0 = 1'b0;
      exp_q.delete();
      for (int g = 0; g < 4; g++) exp_rx[g] = 8'h00;
      prev_mosi = 4'h0;
    end
    j = cyc - t0;
    n = (has_t0 && !rst_q) ? edges_seen(j) : 0;
    exp_ready_now = rst_q ? 1'b0 : (has_t0 ? (j >= 1 + FULL) : 1'b1);
    for (int g = 0; g < 4; g++) begin
      dv_exp = 1'b0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].g == g && exp_q[i].due == cyc) begin
          dv_exp    = 1'b1;
          exp_rx[g] = exp_q[i].val;
          exp_q.delete(i);
        end
      end
      clk_exp  = ((g / 2) != 0) ^ n[0];
      mosi_exp = rst_q ? 1'b0 : (has_t0 ? bit_at(cur_tx, g, n, prev_mosi[g]) : prev_mosi[g]);
      exp_mosi_now[g] = mosi_exp;
      check("spi_clk",  g, 8'(obs_clk[g]),   8'(clk_exp));
      check("mosi",     g, 8'(obs_mosi[g]),  8'(mosi_exp));
      check("tx_ready", g, 8'(obs_ready[g]), 8'(exp_ready_now));
      check("rx_dv",    g, 8'(obs_dv[g]),    8'(dv_exp));
      check("rx_byte",  g, obs_rx[g],        exp_rx[g]);
      if (has_t0 && !rst_q)
        miso_drv[g] = cur_lb ? obs_mosi[g] : bit_at(cur_slv[g], g, n, 1'b0);
      else
        miso_drv[g] = 1'b0;
    end
    tx_dv_drv = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!exp_ready_now && guard < 400) begin
      step();
      guard++;
    end
    if (!exp_ready_now) check("ready_timeout", 0, 8'(exp_ready_now), 8'd1);
  endtask

  // Issue a byte at the first cycle the master is ready.
  task automatic send(input logic [7:0] b, input logic [7:0] slv, input bit lb);
    wait_ready();
    tx_byte_drv = b;
    tx_dv_drv   = 1'b1;
    has_t0 = 1'b1;
    t0     = cyc;
    cur_tx = b;
    cur_lb = lb;
    for (int g = 0; g < 4; g++) begin
      cur_slv[g]   = (g == 0) ? slv : 8'($urandom_range(0, 255));
      prev_mosi[g] = exp_mosi_now[g];
      exp_q.push_back('{g: g,
                        due: cyc + ((g % 2 == 1) ? 2 + FULL : 2 + FULL - H),
                        val: lb ? b : cur_slv[g]});
    end
    step();
  endtask

  // Request while busy: must be ignored.
  task automatic poke(input logic [7:0] b);
    if (!exp_ready_now && !rst_q) begin
      tx_byte_drv = b;
      tx_dv_drv   = 1'b1;
    end
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b2b [4];
    b2b[0] = 8'h03; b2b[1] = 8'h02; b2b[2] = 8'h00; b2b[3] = 8'h00;
    for (int g = 0; g < 4; g++) begin
      cur_slv[g] = 8'h00;
      exp_rx[g]  = 8'h00;
    end

    // Reset held for five cycles, then released.
    idle(5);
    rst_drv = 1'b0;
    idle(3);

    // Directed byte with a known slave reply.
    send(8'hAB, 8'h5C, 1'b0);
    wait_ready();
    idle(3);

    // Busy rejection.
    send(8'h03, 8'h81, 1'b0);
    idle(10);
    poke(8'hFF);
    idle(5);
    poke(8'hFF);
    wait_ready();
    idle(6);

    // Back-to-back bytes.
    for (int i = 0; i < 4; i++) send(b2b[i], 8'($urandom_range(0, 255)), 1'b0);
    wait_ready();
    idle(4);

    // Loopback.
    send(8'hA5, 8'h00, 1'b1);
    wait_ready();
    idle(3);

    // Reset in the cycle showing edge 7, then a clean byte.
    send(8'h96, 8'h69, 1'b0);
    idle(7 * H);
    rst_drv = 1'b1;
    idle(2);
    rst_drv = 1'b0;
    idle(2);
    send(8'h3C, 8'hC3, 1'b0);
    wait_ready();
    idle(3);

    // Randomized traffic.
    repeat (25) begin
      idle($urandom_range(0, 3));
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 30));
        poke(8'($urandom_range(0, 255)));
      end
    end
    wait_ready();
    idle(4);

    check("rx_pending", 0, 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
